// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NREQ
// byte producers. It latches the winning byte, strobes tx_rdy until the
// transmitter reports busy, and then waits for the frame to end plus an idle gap.
// Optional start timeout is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              done,
    output logic [2:0]        done_id,
    output logic              err,
    output logic              active,
    output logic [7:0]        tx_data,
    output logic              tx_rdy,
    input  logic              tx_busy
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE, GAP} state_t;

    state_t      state;
    logic [2:0]  ptr;
    logic [2:0]  cur_id;
    logic [3:0]  gap_cnt;
    logic [7:0]  req_pad;
    logic [63:0] data_pad;
    logic        found;
    logic [2:0]  win;
    logic [3:0]  idx;
    logic [3:0]  nxt;

    // Pad to the 8-requester maximum so a 3-bit index selects exactly.
    assign req_pad  = 8'(req);
    assign data_pad = 64'(req_data);
    assign nxt      = {1'b0, win} + 4'd1;

    // First pending request at or above ptr, wrapping at NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            if (!found && req_pad[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [7:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    // Scheduler FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_id  <= '0;
            gap_cnt <= '0;
            ack     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            active  <= 1'b0;
            tx_rdy  <= 1'b0;
            tx_data <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt  <= '0;
            err     <= 1'b0;
`endif
        end else begin
            ack  <= '0;
            done <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!tx_busy && found) begin
                        tx_data <= data_pad[{win, 3'b000} +: 8];
                        ack     <= NREQ'(8'd1 << win);
                        ptr     <= (nxt == 4'(NREQ)) ? 3'd0 : nxt[2:0];
                        cur_id  <= win;
                        tx_rdy  <= 1'b1;
                        active  <= 1'b1;
                        state   <= STROBE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                STROBE: begin
                    if (tx_busy) begin
                        tx_rdy <= 1'b0;
                        state  <= WAIT_DONE;
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else if (to_cnt == 8'(TIMEOUT - 1)) begin
                        // Transmitter never started: drop the frame, keep ptr advanced.
                        tx_rdy <= 1'b0;
                        err    <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gap_cnt <= 4'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        if (GAP_CYCLES == 0) begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gap_cnt <= 4'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: table vectors, corner-case sequences and randomized traffic
// for uart_tx_sched, with a transmitter stand-in and a transaction-level model.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   ack;
    logic              done, err, active, tx_rdy;
    logic [2:0]        done_id;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .done(done), .done_id(done_id), .err(err), .active(active),
        .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_busy(tx_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after start, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (start + k) % NREQ;
            if (((r >> i) & 4'd1) != 0) return i;
        end
        return -1;
    endfunction

    // Model state and transmitter stand-in controls.
    int   cyc = 0, next_ok = 0, gap_end = 0, acc_cyc = 0, mptr = 0, cur = 0;
    bit   mvalid = 0, inflight = 0, started = 0;
    logic [7:0] m_data = '0;
    logic [2:0] m_id = '0;
    bit   force_low = 0;
    int   busy_len = 14, start_cd = 0, busy_left = 0;
    logic rdy_prev = 1'b0;

    // Per-edge model update, output comparison, then transmitter response.
    always @(posedge clk) begin
        logic [NREQ-1:0]   p_req, e_ack;
        logic [8*NREQ-1:0] p_data, tmp;
        logic              p_busy, p_rst, e_done, e_err;
        int                w;
        p_req = req; p_data = req_data; p_busy = tx_busy; p_rst = rst;
        #1;
        cyc++;
        e_ack = '0; e_done = 0; e_err = 0;
        if (p_rst) begin
            mvalid = 1; inflight = 0; started = 0; mptr = 0;
            m_data = '0; m_id = '0; next_ok = cyc + 1; gap_end = 0;
        end else if (mvalid) begin
            if (inflight) begin
                if (started && !p_busy) begin
                    e_done = 1; m_id = 3'(cur); inflight = 0;
                    gap_end = cyc + GAP; next_ok = cyc + GAP + 1;
                end else if (!started && p_busy) begin
                    started = 1;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (!started && (cyc - acc_cyc) == TOUT) begin
                    e_err = 1; inflight = 0;
                    gap_end = cyc + GAP; next_ok = cyc + GAP + 1;
                end
`endif
            end else if (cyc >= next_ok && !p_busy && p_req != '0) begin
                w = pick(p_req, mptr);
                e_ack = 4'(1 << w);
                tmp = p_data >> (8 * w);
                m_data = tmp[7:0];
                mptr = (w + 1) % NREQ;
                cur = w; inflight = 1; started = 0; acc_cyc = cyc;
            end
        end
        if (mvalid) begin
            check("m_ack", 32'(ack), 32'(e_ack));
            check("m_done", 32'(done), 32'(e_done));
            check("m_err", 32'(err), 32'(e_err));
            check("m_done_id", 32'(done_id), 32'(m_id));
            check("m_tx_data", 32'(tx_data), 32'(m_data));
            check("m_tx_rdy", 32'(tx_rdy), 32'(inflight && !started));
            check("m_active", 32'(active), 32'(inflight || cyc < gap_end));
        end
        if (!rdy_prev && tx_rdy === 1'b1) start_cd = 3;
        rdy_prev = tx_rdy;
        if (force_low) begin
            tx_busy = 1'b0; start_cd = 0; busy_left = 0;
        end else if (start_cd > 0) begin
            start_cd--;
            if (start_cd == 0) begin tx_busy = 1'b1; busy_left = busy_len; end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    task automatic wait_ack(input int limit, output logic [NREQ-1:0] a, output int waited);
        a = '0; waited = 0;
        while (waited < limit) begin
            @(negedge clk); waited++;
            if (ack != '0) begin a = ack; break; end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen, output logic [2:0] id, output int stray);
        seen = 0; id = '0; stray = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (ack != '0) stray++;
            if (done) begin seen = 1; id = done_id; break; end
        end
    endtask

    task automatic wait_busy(input int limit, output bit seen);
        seen = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (tx_busy) begin seen = 1; break; end
        end
    endtask

    typedef struct {
        logic [NREQ-1:0]   rq;
        logic [8*NREQ-1:0] dat;
        logic [NREQ-1:0]   eack;
        logic [7:0]        ebyte;
        logic [2:0]        eid;
    } vec_t;

    initial begin
        vec_t            tbl[7];
        logic [NREQ-1:0] a;
        logic [2:0]      id;
        logic [7:0]      exp_b2b[5];
        int              waited, stray, cnt, last_busy;
        bit              seen;

        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        vec_t            tbl[7];
        logic [NREQ-1:0] a;
        logic [2:0]      id;
        logic [7:0]      exp_b2b[5];
        int              waited, stray, cnt, last_busy;
        bit              seen;

        tbl[0] = '{4'b0100, 32'h00A50000, 4'b0100, 8'hA5, 3'd2};
        tbl[1] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44, 3'd3};
        tbl[2] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11, 3'd0};
        tbl[3] = '{4'b0101, 32'h44332211, 4'b0100, 8'h33, 3'd2};
        tbl[4] = '{4'b0011, 32'h44332211, 4'b0001, 8'h11, 3'd0};
        tbl[5] = '{4'b0010, 32'h44332211, 4'b0010, 8'h22, 3'd1};
        tbl[6] = '{4'b1001, 32'h44332211, 4'b1000, 8'h44, 3'd3};
        exp_b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ack, done, done_id, err, active, tx_rdy, tx_data}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: single requests exercising pointer rotation.
        for (int i = 0; i < 7; i++) begin
            req = tbl[i].rq; req_data = tbl[i].dat;
            wait_ack(40, a, waited);
            check("tbl_ack", 32'(a), 32'(tbl[i].eack));
            check("tbl_tx_data", 32'(tx_data), 32'(tbl[i].ebyte));
            if (i == 0) check("accept_latency", 32'(waited), 32'd1);
            req = '0;
            wait_done(100, seen, id, stray);
            check("tbl_done", 32'(seen), 32'd1);
            check("tbl_done_id", 32'(id), 32'(tbl[i].eid));
            repeat (4) @(negedge clk);
        end

        // All four requesting continuously: strict rotation with a gap.
        req = 4'b1111; req_data = 32'h44332211;
        for (int j = 0; j < 5; j++) begin
            wait_ack(100, a, waited);
            check("b2b_ack", 32'(a), 32'(1 << (j % 4)));
            check("b2b_tx_data", 32'(tx_data), 32'(exp_b2b[j]));
            if (j > 0) check("b2b_gap", 32'(waited >= GAP + 1), 32'd1);
            wait_done(100, seen, id, stray);
            check("b2b_done_id", 32'(id), 32'(j % 4));
        end
        req = '0;
        repeat (6) @(negedge clk);

        // Request arriving while a frame is on the line.
        req = 4'b0001; req_data = 32'hD0000000 | 32'h000000C3;
        wait_ack(40, a, waited);
        check("mid_first_ack", 32'(a), 32'h1);
        req = '0;
        wait_busy(20, seen);
        check("mid_busy_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        req = 4'b1000;
        wait_done(100, seen, id, stray);
        check("mid_no_early_ack", 32'(stray), 32'd0);
        wait_ack(40, a, waited);
        check("mid_ack_after_gap", 32'(waited), 32'(GAP + 1));
        check("mid_ack", 32'(a), 32'h8);
        check("mid_tx_data", 32'(tx_data), 32'hD0);
        req = '0;
        wait_done(100, seen, id, stray);
        repeat (4) @(negedge clk);

        // Withdrawn request: req[1] pulses for one cycle while active.
        req = 4'b0001; req_data = 32'h0000BB5A;
        wait_ack(40, a, waited);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ack[1]) cnt++;
        end
        check("withdrawn_no_ack", 32'(cnt), 32'd0);

        // Reset mid-frame while the transmitter keeps shifting.
        req = 4'b0001; req_data = 32'h0000005A;
        wait_ack(40, a, waited);
        req = '0;
        wait_busy(20, seen);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", 32'({ack, done, done_id, err, active, tx_rdy, tx_data}), 32'd0);
        req = 4'b0001;
        a = '0; waited = 0; last_busy = 1;
        while (waited < 100) begin
            last_busy = int'(tx_busy);
            @(negedge clk); waited++;
            if (ack != '0) begin a = ack; break; end
        end
        check("rst_ack", 32'(a), 32'h1);
        check("rst_ack_busy_low", 32'(last_busy), 32'd0);
        check("rst_held_off", 32'(waited > 2), 32'd1);
        req = '0;
        wait_done(100, seen, id, stray);
        repeat (6) @(negedge clk);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Transmitter never starts: strobe times out.
        force_low = 1;
        req = 4'b0100; req_data = 32'h00770000;
        wait_ack(40, a, waited);
        check("to_ack", 32'(a), 32'h4);
        req = '0;
        cnt = 0; stray = 0; waited = 0;
        for (int n = 0; n < 40; n++) begin
            if (tx_rdy) cnt++;
            if (err) stray++;
            if (done) waited++;
            @(negedge clk);
        end
        check("to_rdy_cycles", 32'(cnt), 32'(TOUT));
        check("to_err_pulses", 32'(stray), 32'd1);
        check("to_no_done", 32'(waited), 32'd0);
        force_low = 0;
        req = 4'b0010; req_data = 32'h00006600;
        wait_ack(40, a, waited);
        check("to_next_ack", 32'(a), 32'h2);
        req = '0;
        wait_done(100, seen, id, stray);
        repeat (4) @(negedge clk);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if (done) busy_len = int'($urandom_range(12, 20));
            for (int i = 0; i < NREQ; i++) begin
                if (req[2'(i)] && ack[2'(i)]) req[2'(i)] = 1'b0;
                else if (req[2'(i)] && $urandom_range(0, 63) == 0) req[2'(i)] = 1'b0;
                else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
                    req[2'(i)] = 1'b1;
                    req_data[5'(8 * i) +: 8] = 8'($urandom);
                end
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (100) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `tx` UART transmitter among `NREQ` byte producers. It arbitrates pending requests and latches the winner's byte. It generates the `rdy` rising edge the transmitter needs, holds `datain` stable for the whole frame, and reports completion per requester. It sits directly in front of `tx`, driving its `datain`/`rdy` and observing its `busy`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 2: idle cycles enforced after each frame before the next arbitration (0..15).
- `TIMEOUT`, 8: cycles allowed from `tx_rdy` rise to `tx_busy` rise (macro-gated; 4..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request per requester; held until `ack`.
- `req_data`  in  8*NREQ  byte per requester; requester i uses bits [8i+7:8i].
- `ack`  out  NREQ  one-hot, one-cycle pulse: request accepted and byte latched.
- `done`  out  1  one-cycle pulse: frame finished on the line.
- `done_id`  out  3  index of the requester whose frame finished; valid with `done`, held after it.
- `err`  out  1  one-cycle pulse: transmitter failed to start (timeout).
- `active`  out  1  high from acceptance until the `GAP` state ends.
- `tx_data`  out  8  to `tx.datain`; stable from acceptance until `done`.
- `tx_rdy`  out  1  to `tx.rdy`.
- `tx_busy`  in  1  from `tx.busy`.

## Operation
- States: `IDLE`, `STROBE`, `WAIT_DONE`, `GAP`.
- **IDLE**
  - Arbitration happens only when `tx_busy`=0 and any `req` bit is set.
  - Winner is the first set bit searching upward from `ptr`, wrapping at `NREQ-1`.
  - On acceptance, at the same edge:
    - `tx_data` <= winner's byte;
    - `ack[winner]` <= 1;
    - `ptr` <= winner+1 mod `NREQ`;
    - `cur_id` <= winner;
    - `tx_rdy` <= 1, `active` <= 1;
    - go to `STROBE`.
- **STROBE**
  - `tx_rdy` stays high.
  - When `tx_busy`=1: `tx_rdy` <= 0, go to `WAIT_DONE`.
- **WAIT_DONE**
  - When `tx_busy`=0: `done` <= 1, `done_id` <= `cur_id`.
  - If `GAP_CYCLES`=0, go directly to `IDLE` with `active` <= 0; otherwise load the gap counter and go to `GAP`.
- **GAP**
  - Count down `GAP_CYCLES`; at 0, `active` <= 0 and go to `IDLE`.
- `ptr` resets to 0, so req0 has highest priority after reset.
- Requests arriving during `STROBE`, `WAIT_DONE` or `GAP` stay pending. They are not lost and not acked.
- A `req` bit that drops before acceptance is never granted.
- `req_data` is sampled only at the acceptance edge.
- `tx_data` is never modified outside acceptance.

## Timing
- Reset values: `ack`=0, `done`=0, `done_id`=0, `err`=0, `active`=0, `tx_rdy`=0, `tx_data`=0, `ptr`=0, state=`IDLE`.
- Acceptance latency: `req` high at edge n (state `IDLE`, `tx_busy`=0) means `ack` and `tx_rdy` are high in cycle n+1.
- `tx_busy` is expected to rise 3 cycles after `tx_rdy` rises, because of the transmitter's edge detect and start pipeline.
- `tx_rdy` returns low before the frame ends. This guarantees a fresh rising edge for every frame.
- Frame occupancy is 12 bit-slots after `busy` rises: start, 8 data, parity, stop, release.
- Back-to-back period is (`tx_busy` high time) + 5 + `GAP_CYCLES` cycles.
- Reset mid-frame:
  - Outputs return to reset values in the cycle after `rst`.
  - The block stays in `IDLE` without accepting until `tx_busy`=0. This covers a transmitter that is still shifting.
- Simultaneous `req` from all requesters: exactly one `ack` bit per acceptance; rotation is strict.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined:
  - A counter runs in `STROBE`.
  - If `TIMEOUT` cycles elapse with `tx_busy`=0:
    - `tx_rdy` <= 0;
    - `err` pulses 1 cycle;
    - `done` does not pulse;
    - the block goes to `GAP` (or to `IDLE` if `GAP_CYCLES`=0).
  - The frame is dropped; `ptr` remains advanced.
- Not defined:
  - `STROBE` waits indefinitely for `tx_busy`.
  - `err` is tied to 0 and the counter is absent.

## Test plan
- **Single request:** `req`=4'b0100, byte 0xA5 in slot 2, with a real `tx` instance.
  - `ack`=4'b0100 one cycle later; `tx` line shows 0,1,0,1,0,0,1,0,1,0,1 (LSB first, parity 0, stop 1).
  - `done` pulses with `done_id`=2.
- **All four requesting continuously** with bytes 0x11/0x22/0x33/0x44: `ack` order 0,1,2,3,0; `tx_data` sequence 0x11,0x22,0x33,0x44,0x11; ≥`GAP_CYCLES` idle cycles between frames.
- **Request during frame:** `req[3]` asserted while frame 0 is in `WAIT_DONE`.
  - No `ack` until `GAP` ends; then `ack`=4'b1000.
- **Reset mid-frame:** `rst` at bit 4 of a frame.
  - All outputs 0 next cycle.
  - With `req[0]` held, the next `ack` occurs only after `tx_busy` falls.
- **Timeout** (macro defined, `tx_busy` forced 0): `tx_rdy` high for 8 cycles, then low; `err` pulses once; no `done`; next request is accepted after the gap.
- **Withdrawn request:** `req[1]` pulsed for 1 cycle while `active`=1; no `ack[1]` ever issued.
